// File: rtl/game_pkg.sv
// Shared state codes and field widths for the game sequencer.
package game_pkg;

    localparam int LIVES_W = 2;
    localparam int TIME_W  = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_DYING  = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_PLAY   = ST_PLAY,
        S_DYING  = ST_DYING,
        S_OVER   = ST_OVER
    } state_t;

endpackage

// File: rtl/game_timer.sv
// Per-life countdown: frame_tick prescaler feeding a saturating seconds counter.
module game_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60,
    parameter int TIME_LIMIT    = 99
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              enable,
    input  logic              frame_tick,
    output logic [TIME_W-1:0] time_left,
    output logic              zero
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;

    // Load restarts a full second; otherwise count frames and step seconds down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            time_left <= TIME_W'(TIME_LIMIT);
        end else if (load) begin
            prescaler <= '0;
            time_left <= load_val;
        end else if (enable && frame_tick) begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                if (time_left != '0)
                    time_left <= time_left - TIME_W'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    assign zero = (time_left == '0);

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: start/respawn/time-out/win/game-over control for the character blocks.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int TIME_LIMIT    = 99,
    parameter int TICKS_PER_SEC = 60,
    parameter int DIE_TICKS     = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_start,
    input  logic               frame_tick,
    input  logic               collide,
    input  logic               goal,
    output logic               kong_rst,
    output logic               start,
    output logic               over,
    output logic               win,
    output logic [LIVES_W-1:0] lives,
    output logic [TIME_W-1:0]  time_left,
    output logic [2:0]         game_state
);

    localparam int DW = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
    localparam logic [DW-1:0]      DIE_LAST   = DW'(DIE_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t             state, state_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic               win_nxt;
    logic [DW-1:0]      die_cnt, die_nxt;
    logic               start_pend, start_pend_nxt;
    logic               key_prev;
    logic               rise;
    logic               timer_zero;
    logic               timer_load;
    logic               timer_en;

    assign rise = key_start & ~key_prev;

    game_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TIME_LIMIT    (TIME_LIMIT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_val   (TIME_W'(TIME_LIMIT)),
        .enable     (timer_en),
        .frame_tick (frame_tick),
        .time_left  (time_left),
        .zero       (timer_zero)
    );

    // State and datapath registers; reset wins over any in-flight game.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lives      <= LIVES_INIT;
            win        <= 1'b0;
            die_cnt    <= '0;
            start_pend <= 1'b0;
            key_prev   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lives      <= lives_nxt;
            win        <= win_nxt;
            die_cnt    <= die_nxt;
            start_pend <= start_pend_nxt;
            key_prev   <= key_start;
        end
    end

    // Next-state, lives/win updates and control pulses.
    always_comb begin
        state_nxt      = state;
        lives_nxt      = lives;
        win_nxt        = win;
        die_nxt        = die_cnt;
        start_pend_nxt = 1'b0;
        timer_load     = 1'b0;
        timer_en       = 1'b0;
        kong_rst       = 1'b0;
        start          = 1'b0;
        over           = 1'b0;

        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_LAUNCH;
                    lives_nxt = LIVES_INIT;
                    win_nxt   = 1'b0;
                end
            end
            S_LAUNCH: begin
                kong_rst       = 1'b1;
                timer_load     = 1'b1;
                die_nxt        = '0;
                start_pend_nxt = 1'b1;
                state_nxt      = S_PLAY;
            end
            S_PLAY: begin
                timer_en = 1'b1;
                start    = start_pend;
                // Collision outranks time-out, which outranks reaching the goal.
                if (collide || timer_zero) begin
                    if (lives == LIVES_W'(1)) begin
                        lives_nxt = '0;
                        win_nxt   = 1'b0;
                        state_nxt = S_OVER;
                    end else begin
                        lives_nxt = lives - LIVES_W'(1);
                        state_nxt = S_DYING;
                    end
                end else if (goal) begin
                    win_nxt   = 1'b1;
                    state_nxt = S_OVER;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (die_cnt == DIE_LAST)
                        state_nxt = S_LAUNCH;
                    else
                        die_nxt = die_cnt + DW'(1);
                end
            end
            S_OVER: begin
                over = 1'b1;
                if (rise) begin
                    state_nxt = S_LAUNCH;
                    lives_nxt = LIVES_INIT;
                    win_nxt   = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with small timing parameters.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collide = 1'b0;
    logic       goal = 1'b0;
    logic       kong_rst, start, over, win;
    logic [1:0] lives;
    logic [6:0] time_left;
    logic [2:0] game_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .LIVES         (2),
        .TIME_LIMIT    (3),
        .TICKS_PER_SEC (2),
        .DIE_TICKS     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .frame_tick (frame_tick),
        .collide    (collide),
        .goal       (goal),
        .kong_rst   (kong_rst),
        .start      (start),
        .over       (over),
        .win        (win),
        .lives      (lives),
        .time_left  (time_left),
        .game_state (game_state)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        checks++; if ({kong_rst, start, over, win} !== 4'b0000) begin errors++; $display("FAIL reset_outs got=%b exp=0000", {kong_rst, start, over, win}); end
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL reset_lives got=%0d exp=2", lives); end
        checks++; if (time_left !== 7'd3) begin errors++; $display("FAIL reset_time got=%0d exp=3", time_left); end
    endtask

    // Key raised at cycle 10 (counted from reset release) and held 20 cycles.
    task automatic test_start();
        int kr_cnt = 0;
        int st_cnt = 0;
        for (int c = 1; c < 10; c++) cyc();
        key_start = 1'b1;
        for (int c = 11; c <= 30; c++) begin
            cyc();
            checks++; if (kong_rst !== (c == 11)) begin errors++; $display("FAIL start_kong_rst cyc=%0d got=%b exp=%b", c, kong_rst, (c == 11)); end
            checks++; if (start !== (c == 12)) begin errors++; $display("FAIL start_pulse cyc=%0d got=%b exp=%b", c, start, (c == 12)); end
            if (kong_rst) kr_cnt++;
            if (start) st_cnt++;
        end
        key_start = 1'b0;
        checks++; if (st_cnt != 1 || kr_cnt != 1) begin errors++; $display("FAIL start_count got=%0d/%0d exp=1/1", kr_cnt, st_cnt); end
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL start_state got=%0d exp=2", game_state); end
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL start_lives got=%0d exp=2", lives); end
        checks++; if (time_left !== 7'd3) begin errors++; $display("FAIL start_time got=%0d exp=3", time_left); end
    endtask

    task automatic test_timeout();
        logic [6:0] exp_t [6];
        exp_t = '{7'd3, 7'd2, 7'd2, 7'd1, 7'd1, 7'd0};
        for (int k = 0; k < 6; k++) begin
            tick_frame();
            checks++; if (time_left !== exp_t[k]) begin errors++; $display("FAIL timeout_time tick=%0d got=%0d exp=%0d", k + 1, time_left, exp_t[k]); end
            checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL timeout_play tick=%0d got=%0d exp=2", k + 1, game_state); end
            if (k < 5) cyc();
        end
        cyc();
        checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL timeout_dying got=%0d exp=3", game_state); end
        checks++; if (lives !== 2'd1) begin errors++; $display("FAIL timeout_lives got=%0d exp=1", lives); end
        tick_frame();
        checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL die_hold got=%0d exp=3", game_state); end
        cyc();
        tick_frame();
        checks++; if (game_state !== 3'd1 || kong_rst !== 1'b1) begin errors++; $display("FAIL respawn_launch got=%0d/%b exp=1/1", game_state, kong_rst); end
        cyc();
        checks++; if (start !== 1'b1 || kong_rst !== 1'b0) begin errors++; $display("FAIL respawn_start got=%b/%b exp=1/0", start, kong_rst); end
        checks++; if (time_left !== 7'd3 || lives !== 2'd1) begin errors++; $display("FAIL respawn_vals got=%0d/%0d exp=3/1", time_left, lives); end
        cyc();
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL respawn_start_once got=%b exp=0", start); end
    endtask

    task automatic test_last_life();
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        checks++; if (game_state !== 3'd4 || over !== 1'b1) begin errors++; $display("FAIL last_over got=%0d/%b exp=4/1", game_state, over); end
        checks++; if (lives !== 2'd0 || win !== 1'b0) begin errors++; $display("FAIL last_lives got=%0d/%b exp=0/0", lives, win); end
        collide = 1'b1;
        goal = 1'b1;
        frame_tick = 1'b1;
        repeat (3) cyc();
        collide = 1'b0;
        goal = 1'b0;
        frame_tick = 1'b0;
        checks++; if (game_state !== 3'd4 || lives !== 2'd0 || win !== 1'b0 || over !== 1'b1) begin errors++; $display("FAIL over_ignore got=%0d/%0d/%b/%b exp=4/0/0/1", game_state, lives, win, over); end
        key_start = 1'b1;
        cyc();
        checks++; if (kong_rst !== 1'b1 || lives !== 2'd2 || over !== 1'b0) begin errors++; $display("FAIL restart_launch got=%b/%0d/%b exp=1/2/0", kong_rst, lives, over); end
        cyc();
        checks++; if (start !== 1'b1 || game_state !== 3'd2) begin errors++; $display("FAIL restart_start got=%b/%0d exp=1/2", start, game_state); end
        key_start = 1'b0;
        cyc();
    endtask

    task automatic test_simultaneous();
        collide = 1'b1;
        goal = 1'b1;
        cyc();
        collide = 1'b0;
        goal = 1'b0;
        checks++; if (game_state !== 3'd3 || lives !== 2'd1 || win !== 1'b0) begin errors++; $display("FAIL simul_death got=%0d/%0d/%b exp=3/1/0", game_state, lives, win); end
        tick_frame();
        tick_frame();
        cyc();
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL simul_respawn got=%0d exp=2", game_state); end
        goal = 1'b1;
        cyc();
        checks++; if (game_state !== 3'd4 || win !== 1'b1 || lives !== 2'd1) begin errors++; $display("FAIL goal_win got=%0d/%b/%0d exp=4/1/1", game_state, win, lives); end
        cyc();
        goal = 1'b0;
        key_start = 1'b1;
        cyc();
        checks++; if (win !== 1'b0 || lives !== 2'd2 || game_state !== 3'd1) begin errors++; $display("FAIL goal_restart got=%b/%0d/%0d exp=0/2/1", win, lives, game_state); end
        key_start = 1'b0;
        cyc();
    endtask

    task automatic test_mid_reset();
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL midrst_pre got=%0d exp=3", game_state); end
        tick_frame();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (game_state !== 3'd0 || {kong_rst, start, over, win} !== 4'b0000) begin errors++; $display("FAIL midrst_state got=%0d/%b exp=0/0000", game_state, {kong_rst, start, over, win}); end
        checks++; if (lives !== 2'd2 || time_left !== 7'd3) begin errors++; $display("FAIL midrst_vals got=%0d/%0d exp=2/3", lives, time_left); end
        tick_frame();
        cyc();
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL midrst_die_cleared got=%0d exp=0", game_state); end
        collide = 1'b1;
        goal = 1'b1;
        frame_tick = 1'b1;
        repeat (4) cyc();
        collide = 1'b0;
        goal = 1'b0;
        frame_tick = 1'b0;
        checks++; if (game_state !== 3'd0 || lives !== 2'd2 || time_left !== 7'd3 || win !== 1'b0) begin errors++; $display("FAIL idle_ignore got=%0d/%0d/%0d/%b exp=0/2/3/0", game_state, lives, time_left, win); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_start();
        test_timeout();
        test_last_life();
        test_simultaneous();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game sequencer that drives the kong character block's control inputs (kong_rst, start, over) from player input and game events. It sequences start, death/respawn, time-out, win and game-over. It also owns the lives counter and the countdown timer. It sits between the debounced key inputs, collision logic and the kong/mario character blocks, and its status outputs feed the VGA HUD.

Parameters:
LIVES, 3, lives loaded at game start (1..3)
TIME_LIMIT, 99, countdown seconds per life (1..127)
TICKS_PER_SEC, 60, frame_tick pulses per timer second
DIE_TICKS, 90, frame_tick pulses spent in DYING before respawn

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_start  in  1  debounced start key, level
frame_tick  in  1  one-cycle pulse per video frame
collide  in  1  player/enemy collision, level, sampled each cycle
goal  in  1  player reached goal, level
kong_rst  out  1  one-cycle reset pulse to character blocks
start  out  1  one-cycle start pulse to character blocks
over  out  1  game-over level to character blocks
win  out  1  last game ended by goal
lives  out  2  remaining lives
time_left  out  7  remaining seconds, binary
game_state  out  3  current FSM state, for HUD

Behaviour:
- Reset is synchronous and active-high and overrides everything, including mid-game. After reset:
  - state=IDLE, kong_rst=0, start=0, over=0, win=0
  - lives=LIVES, time_left=TIME_LIMIT
  - prescaler=0, die counter=0, key_prev=0
- Key edge: key_prev is registered each cycle. rise = key_start & ~key_prev. A held key produces exactly one rise.
- States and encoding: IDLE=0, LAUNCH=1, PLAY=2, DYING=3, OVER=4. Codes 5..7 go to IDLE on the next cycle.
- IDLE:
  - on rise -> LAUNCH; load lives=LIVES, win=0.
- LAUNCH (exactly one cycle):
  - kong_rst=1 for this cycle.
  - load time_left=TIME_LIMIT; clear prescaler and die counter.
  - next state is PLAY.
- PLAY:
  - start=1 on the first PLAY cycle only (registered flag set by LAUNCH).
  - Timing: if rise is seen at cycle t, kong_rst is high at t+1 and start is high at t+2.
  - On frame_tick the prescaler increments. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements; time_left saturates at 0.
  - Event priority, evaluated in the same cycle: collide > (time_left==0) > goal.
  - Death (collide, or time_left==0):
    - if lives==1: lives=0, -> OVER, win=0.
    - otherwise: lives decrements, -> DYING.
  - goal: -> OVER, win=1; lives unchanged.
- DYING:
  - die counter increments on frame_tick.
  - when the count reaches DIE_TICKS-1 and a frame_tick occurs -> LAUNCH (respawn; lives not reloaded).
  - collide, goal and key_start are ignored.
- OVER:
  - over=1 combinationally from state, for every OVER cycle.
  - on rise -> LAUNCH; reload lives=LIVES, win=0.
- collide and goal are ignored outside PLAY.
- frame_tick is ignored in IDLE, LAUNCH and OVER.
- time_left and lives are held in all states except where updated above.
- start and kong_rst are never high in the same cycle.
- over is never high together with start.

Decomposition:
- Package game_pkg holds:
  - state localparams ST_IDLE..ST_OVER, 3-bit;
  - widths LIVES_W=2 and TIME_W=7.
- One sub-module, game_timer, contains the frame-tick prescaler plus the saturating second countdown. Its ports:
  - load (in), load value (in);
  - enable (PLAY only), frame_tick (in);
  - time_left (out), zero flag (out).
- game_ctrl instantiates game_timer and implements the FSM, the lives counter and the edge detector.

Test Plan:
All scenarios use LIVES=2, TIME_LIMIT=3, TICKS_PER_SEC=2, DIE_TICKS=2.
- Start sequence: hold rst for 3 cycles, release, then raise key_start at cycle 10 and hold it for 20 cycles.
  - Required: kong_rst=1 only at cycle 11; start=1 only at cycle 12; game_state=2; lives=2; time_left=3.
  - Holding the key produces no further start pulses.
- Timeout: in PLAY, with no collision, issue 6 frame_ticks.
  - Required: time_left steps 3->2->1->0, then -> DYING with lives=1.
  - After 2 more frame_ticks: kong_rst pulse, then start pulse; time_left=3.
- Collide with last life: from lives=1, assert collide.
  - Required: next cycle game_state=4, over=1, lives=0, win=0.
  - A key rise then gives kong_rst, then start, with lives=2.
- Simultaneous events: assert collide and goal in the same PLAY cycle.
  - Required: death path taken (DYING, lives 2->1), win=0.
  - A separate goal-only event gives OVER with win=1 and lives unchanged.
- Mid-game reset: assert rst for 1 cycle during DYING.
  - Required: next cycle IDLE with all outputs at reset values.
  - collide and goal asserted while in IDLE and OVER cause no change.
